// File: rtl/raisin64_pkg.sv
// Shared definitions for the raisin64 instruction fetch path.
// Provides the fetch word size, prefetch FSM states and queue entry layout.
package raisin64_pkg;

    localparam int INST_WORD_BYTES = 8;
    localparam int ENTRY_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } pf_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] data;
    } pf_entry_t;

endpackage

// File: rtl/imem_prefetch_fifo.sv
// Synchronous DEPTH-entry queue of {pc, word} pairs with a flush input.
// Ports: clk, rst_n, flush, push/push_data, pop, head, count.
module prefetch_fifo
    import raisin64_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    push,
    input  logic [ENTRY_W-1:0]      push_data,
    input  logic                    pop,
    output logic [ENTRY_W-1:0]      head,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;

    assign head = mem[rd_ptr];

    // Data storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imem_prefetch.sv
// Instruction prefetcher: one outstanding memory request, results queued.
// Ports: mem_* (memory side), out_* (fetch side), jump_pc/do_jump redirect.
// Optional macro IMEM_PREFETCH_BYPASS_EN forwards a response straight
// to out_* when the queue is empty.
module imem_prefetch
    import raisin64_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] mem_addr,
    output logic        mem_addr_valid,
    input  logic [63:0] mem_data,
    input  logic        mem_data_valid,
    output logic [63:0] out_data,
    output logic [63:0] out_pc,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [63:0] jump_pc,
    input  logic        do_jump
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [63:0] STEP = 64'(INST_WORD_BYTES);
    localparam logic [63:0] WORD_MASK = ~(STEP - 64'd1);
    localparam logic [63:0] RESET_WORD = RESET_PC & WORD_MASK;

    pf_state_t          state;
    logic [63:0]        fetch_pc;
    logic [63:0]        jump_word;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_left;
    logic [ENTRY_W-1:0] head_raw;
    pf_entry_t          head;
    pf_entry_t          push_entry;
    logic               resp;
    logic               bypass;
    logic               queued;
    logic               fifo_pop;
    logic               fifo_push;
    logic               room;

    assign jump_word = jump_pc & WORD_MASK;
    assign queued    = count != '0;
    assign resp      = (state == REQ) && mem_data_valid;

`ifdef IMEM_PREFETCH_BYPASS_EN
    assign bypass = resp && !queued;
`else
    assign bypass = 1'b0;
`endif

    assign head      = pf_entry_t'(head_raw);
    assign out_valid = queued || bypass;
    assign out_data  = queued ? head.data
                     : (bypass ? mem_data : '0);
    assign out_pc    = queued ? head.pc
                     : (bypass ? fetch_pc : '0);

    // A redirect wins over both queue ports.
    assign fifo_pop   = queued && out_ready && !do_jump;
    assign fifo_push  = resp && !do_jump
                     && !(bypass && out_ready);
    assign push_entry = '{pc: fetch_pc, data: mem_data};

    assign count_left = count - CW'(fifo_pop);
    assign room       = count_left < CW'(DEPTH);

    prefetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (do_jump),
        .push     (fifo_push),
        .push_data(push_entry),
        .pop      (fifo_pop),
        .head     (head_raw),
        .count    (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            fetch_pc       <= RESET_WORD;
            mem_addr       <= RESET_WORD;
            mem_addr_valid <= 1'b0;
        end else begin
            if (do_jump)
                fetch_pc <= jump_word;
            else if (resp)
                fetch_pc <= fetch_pc + STEP;

            unique case (state)
                IDLE: begin
                    if (room) begin
                        state          <= REQ;
                        mem_addr_valid <= 1'b1;
                        mem_addr       <= do_jump ? jump_word
                                                  : fetch_pc;
                    end
                end
                REQ: begin
                    if (mem_data_valid) begin
                        state          <= IDLE;
                        mem_addr_valid <= 1'b0;
                    end else if (do_jump) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (mem_data_valid) begin
                        state          <= IDLE;
                        mem_addr_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    mem_addr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_prefetch.sv
// Self-checking bench for imem_prefetch against a queue-based model.
// Honours IMEM_PREFETCH_BYPASS_EN when deciding same-cycle visibility.
module tb_imem_prefetch;

`ifdef IMEM_PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int DEPTH = 4;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] mem_addr;
    logic        mem_addr_valid;
    logic [63:0] mem_data = '0;
    logic        mem_data_valid = 1'b0;
    logic [63:0] out_data;
    logic [63:0] out_pc;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] jump_pc = '0;
    logic        do_jump = 1'b0;

    logic [63:0] w_mem_addr;
    logic        w_mem_addr_valid;
    logic [63:0] w_mem_data = '0;
    logic        w_mem_data_valid = 1'b0;
    logic [63:0] w_out_data;
    logic [63:0] w_out_pc;
    logic        w_out_valid;
    logic        w_out_ready = 1'b0;
    logic [63:0] w_jump_pc = '0;
    logic        w_do_jump = 1'b0;

    always #5 clk = ~clk;

    imem_prefetch #(.DEPTH(DEPTH), .RESET_PC(64'h0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_addr_valid(mem_addr_valid),
        .mem_data(mem_data), .mem_data_valid(mem_data_valid),
        .out_data(out_data), .out_pc(out_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .jump_pc(jump_pc), .do_jump(do_jump)
    );

    imem_prefetch #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(w_mem_addr), .mem_addr_valid(w_mem_addr_valid),
        .mem_data(w_mem_data), .mem_data_valid(w_mem_data_valid),
        .out_data(w_out_data), .out_pc(w_out_pc),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .jump_pc(w_jump_pc), .do_jump(w_do_jump)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: pcs waiting in the queue, next expected request.
    logic [63:0] q[$];
    logic [63:0] exp_req;
    logic [63:0] lat_addr;
    logic [63:0] resp_addr;
    bit          busy;
    bit          cur;
    bit          resp_now;
    bit          resp_cur;
    bit          gap_chk;
    int          cnt;
    int          gap;
    int          pops;
    int          lat_lo = 1;
    int          lat_hi = 1;

    function automatic logic [63:0] word_of(input logic [63:0] a);
        return a ^ 64'h0123_4567_89AB_CDEF ^ {a[31:0], a[63:32]};
    endfunction

    task automatic cycle(input bit rdy, input bit jmp,
                         input logic [63:0] tgt);
        bit          byp;
        bit          ev;
        logic [63:0] pc;
        @(negedge clk);
        mem_data_valid = 1'b0;
        resp_now = 1'b0;
        if (busy) begin
            tests++;
            if (mem_addr_valid !== 1'b1 || mem_addr !== lat_addr) begin
                fails++;
                $display("FAIL hold: valid=%0b addr=%h want 1 %h",
                         mem_addr_valid, mem_addr, lat_addr);
            end
            cnt--;
            if (cnt == 0) begin
                mem_data_valid = 1'b1;
                mem_data = word_of(lat_addr);
                resp_now = 1'b1;
                resp_cur = cur;
                resp_addr = lat_addr;
                busy = 1'b0;
            end
        end else if (mem_addr_valid) begin
            tests++;
            if (mem_addr !== exp_req) begin
                fails++;
                $display("FAIL req_addr: got %h want %h",
                         mem_addr, exp_req);
            end
            if (gap_chk) begin
                tests++;
                if (gap > 1) begin
                    fails++;
                    $display("FAIL req_gap: got %0d want <=1", gap);
                end
            end
            gap = 0;
            busy = 1'b1;
            cur = 1'b1;
            lat_addr = mem_addr;
            cnt = int'($urandom_range(lat_hi, lat_lo));
        end else begin
            gap++;
        end
        out_ready = rdy;
        do_jump = jmp;
        jump_pc = tgt;
        #1;
        if (jmp) begin
            q.delete();
            exp_req = tgt & ~64'h7;
            cur = 1'b0;
        end else begin
            byp = BYP && resp_now && resp_cur && q.size() == 0;
            ev = q.size() > 0 || byp;
            tests++;
            if (out_valid !== ev) begin
                fails++;
                $display("FAIL out_valid: got %0b want %0b",
                         out_valid, ev);
            end
            if (ev) begin
                pc = (q.size() > 0) ? q[0] : resp_addr;
                tests++;
                if (out_pc !== pc || out_data !== word_of(pc)) begin
                    fails++;
                    $display("FAIL head: pc=%h data=%h want %h %h",
                             out_pc, out_data, pc, word_of(pc));
                end
                if (rdy) begin
                    pops++;
                    if (q.size() > 0)
                        void'(q.pop_front());
                end
            end
            if (resp_now && resp_cur) begin
                if (!(byp && rdy))
                    q.push_back(resp_addr);
                exp_req = exp_req + 64'd8;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || mem_addr_valid !== 1'b0 ||
            mem_addr !== 64'h0 || out_data !== 64'h0 ||
            out_pc !== 64'h0) begin
            fails++;
            $display("FAIL reset: ov=%0b av=%0b a=%h d=%h pc=%h want 0",
                     out_valid, mem_addr_valid, mem_addr,
                     out_data, out_pc);
        end
        tests++;
        if (w_mem_addr !== WRAP_PC || w_mem_addr_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_wrap: a=%h av=%0b want %h 0",
                     w_mem_addr, w_mem_addr_valid, WRAP_PC);
        end
        q.delete();
        exp_req = 64'h0;
        busy = 1'b0;
        cur = 1'b0;
        gap = 0;
        pops = 0;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, '0);
        tests++;
        if (mem_addr_valid !== 1'b1 || w_mem_addr_valid !== 1'b1) begin
            fails++;
            $display("FAIL first_req: av=%0b wav=%0b want 1 1",
                     mem_addr_valid, w_mem_addr_valid);
        end
    endtask

    task automatic test_stream();
        int p0;
        lat_lo = 1;
        lat_hi = 1;
        p0 = pops;
        gap = 0;
        gap_chk = 1'b1;
        repeat (40) cycle(1'b1, 1'b0, '0);
        gap_chk = 1'b0;
        tests++;
        if (pops - p0 < 10) begin
            fails++;
            $display("FAIL stream_rate: got %0d pops want >=10",
                     pops - p0);
        end
    endtask

    task automatic test_full();
        lat_lo = 1;
        lat_hi = 3;
        repeat (30) cycle(1'b0, 1'b0, '0);
        tests++;
        if (q.size() != DEPTH || mem_addr_valid !== 1'b0) begin
            fails++;
            $display("FAIL full: queued=%0d av=%0b want %0d 0",
                     q.size(), mem_addr_valid, DEPTH);
        end
        cycle(1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        tests++;
        if (mem_addr_valid !== 1'b1) begin
            fails++;
            $display("FAIL refill: av=%0b want 1", mem_addr_valid);
        end
        repeat (20) cycle(1'b1, 1'b0, '0);
    endtask

    task automatic wait_new_req(input logic [63:0] want,
                                input string name);
        int n = 0;
        while (!(busy && cur) && n < 30) begin
            cycle(1'b0, 1'b0, '0);
            n++;
        end
        tests++;
        if (!(busy && cur) || lat_addr !== want) begin
            fails++;
            $display("FAIL %s: req=%h busy=%0b want %h",
                     name, lat_addr, busy, want);
        end
    endtask

    task automatic test_jump();
        int n = 0;
        lat_lo = 3;
        lat_hi = 3;
        cycle(1'b1, 1'b1, 64'h0);
        while (!(busy && cur && lat_addr == 64'h18 && cnt >= 2)
               && n < 100) begin
            cycle(1'b1, 1'b0, '0);
            n++;
        end
        tests++;
        if (!(busy && lat_addr == 64'h18)) begin
            fails++;
            $display("FAIL jump_setup: req=%h busy=%0b want 18 1",
                     lat_addr, busy);
        end
        cycle(1'b0, 1'b1, 64'h1004);
        cycle(1'b0, 1'b0, '0);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL jump_flush: ov=%0b want 0", out_valid);
        end
        wait_new_req(64'h1000, "jump_target");
        repeat (15) cycle(1'b1, 1'b0, '0);
    endtask

    task automatic test_jump_resp();
        int n = 0;
        lat_lo = 2;
        lat_hi = 2;
        while (!(q.size() > 0 && busy && cur && cnt == 1) && n < 100) begin
            cycle(1'b0, 1'b0, '0);
            n++;
        end
        cycle(1'b1, 1'b1, 64'h2008);
        tests++;
        if (mem_data_valid !== 1'b1 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL jr_setup: dv=%0b ov=%0b want 1 1",
                     mem_data_valid, out_valid);
        end
        cycle(1'b0, 1'b0, '0);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL jr_empty: ov=%0b want 0", out_valid);
        end
        wait_new_req(64'h2008, "jr_target");
        repeat (15) cycle(1'b1, 1'b0, '0);
    endtask

    task automatic test_bypass();
        int n = 0;
        lat_lo = 1;
        lat_hi = 1;
        cycle(1'b1, 1'b1, 64'h3000);
        cycle(1'b1, 1'b0, '0);
        while (!(resp_now && resp_cur) && n < 20) begin
            cycle(1'b1, 1'b0, '0);
            n++;
        end
        tests++;
        if (!resp_now || out_valid !== BYP) begin
            fails++;
            $display("FAIL bypass_same: ov=%0b want %0b",
                     out_valid, BYP);
        end
        cycle(1'b1, 1'b0, '0);
        tests++;
        if (out_valid !== !BYP) begin
            fails++;
            $display("FAIL bypass_next: ov=%0b want %0b",
                     out_valid, !BYP);
        end
        repeat (10) cycle(1'b1, 1'b0, '0);
    endtask

    task automatic test_random();
        int p0;
        logic [63:0] t;
        lat_lo = 1;
        lat_hi = 3;
        p0 = pops;
        for (int i = 0; i < 300; i++) begin
            t = {32'($urandom), 32'($urandom)};
            cycle($urandom_range(3, 0) != 0,
                  $urandom_range(19, 0) == 0, t);
        end
        tests++;
        if (pops - p0 < 20) begin
            fails++;
            $display("FAIL random_rate: got %0d pops want >=20",
                     pops - p0);
        end
    endtask

    task automatic test_wrap();
        tests++;
        if (w_mem_addr_valid !== 1'b1 || w_mem_addr !== WRAP_PC) begin
            fails++;
            $display("FAIL wrap_first: av=%0b a=%h want 1 %h",
                     w_mem_addr_valid, w_mem_addr, WRAP_PC);
        end
        w_mem_data = word_of(WRAP_PC);
        w_mem_data_valid = 1'b1;
        cycle(1'b1, 1'b0, '0);
        w_mem_data_valid = 1'b0;
        tests++;
        if (w_out_valid !== 1'b1 || w_out_pc !== WRAP_PC ||
            w_out_data !== word_of(WRAP_PC)) begin
            fails++;
            $display("FAIL wrap_head: ov=%0b pc=%h d=%h want 1 %h %h",
                     w_out_valid, w_out_pc, w_out_data,
                     WRAP_PC, word_of(WRAP_PC));
        end
        cycle(1'b1, 1'b0, '0);
        tests++;
        if (w_mem_addr_valid !== 1'b1 || w_mem_addr !== 64'h0) begin
            fails++;
            $display("FAIL wrap_second: av=%0b a=%h want 1 0",
                     w_mem_addr_valid, w_mem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_jump();
        test_jump_resp();
        test_bypass();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
